// File: rtl/ppu_pkg.sv
// Shared PPU types and palette helpers, used by both the read client and
// the CPU-side $2007 write path.
package ppu_pkg;

  localparam logic [13:0] PAL_BASE  = 14'h3F00;
  localparam logic [5:0]  GREY_MASK = 6'h30;

  typedef logic [4:0] pal_index_t;
  typedef logic [5:0] nes_color_t;

  // Sprite-palette colour 0 entries alias the background ones.
  function automatic pal_index_t pal_mirror(input pal_index_t idx);
    pal_mirror = (idx[4] && idx[1:0] == 2'b00) ? {1'b0, idx[3:0]} : idx;
  endfunction

endpackage

// File: rtl/palette_reader.sv
// Palette RAM read client: pixel index stream in, NES colour stream out,
// two-stage pipeline with registered RAM address and end-of-line tagging.
module palette_reader import ppu_pkg::*; #(
  parameter logic [13:0] PAL_BASE    = ppu_pkg::PAL_BASE,
  parameter int unsigned LINE_PIXELS = 256,
  parameter int unsigned XW          = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [4:0]  pix_index,
  input  logic        greyscale,
  input  logic        frame_start,
  output logic [13:0] r_addr,
  input  logic [7:0]  r_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_color,
  output logic        out_eol
);

  localparam logic [XW:0] EOL_AT = (XW+1)'(LINE_PIXELS - 1);

  logic          s1_valid;
  pal_index_t    s1_off;
  logic          s1_grey;
  logic [XW-1:0] x;

  logic          adv, in_hs, out_hs, xfer;
  pal_index_t    st0_off;
  nes_color_t    grey_mask;
  logic [XW:0]   lookahead;
  logic          unused_rdata_hi;

  always_comb begin
    adv       = ~out_valid | out_ready;
    pix_ready = ~s1_valid | adv;
    in_hs     = pix_valid & pix_ready;
    out_hs    = out_valid & out_ready;
    xfer      = s1_valid & adv;
    st0_off   = (pix_index[1:0] == 2'b00) ? '0 : pal_mirror(pix_index);
    grey_mask = s1_grey ? GREY_MASK : '1;
    // Out holds at most one pixel, and on a transfer it is leaving this cycle.
    lookahead = {1'b0, x} + (XW+1)'(out_valid);
  end

  assign r_addr          = PAL_BASE | {{(14-5){1'b0}}, s1_off};
  assign unused_rdata_hi = ^r_data[7:6];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_off   <= '0;
      s1_grey  <= 1'b0;
    end else begin
      s1_valid <= in_hs | (s1_valid & ~adv);
      if (in_hs) begin
        s1_off  <= st0_off;
        s1_grey <= greyscale;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_color <= '0;
      out_eol   <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_color <= r_data[5:0] & grey_mask;
      out_eol   <= (lookahead == EOL_AT);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)            x <= '0;
    else if (frame_start) x <= '0;
    else if (out_hs)      x <= out_eol ? '0 : x + 1'b1;
  end

endmodule

// File: tb/tb_palette_reader.sv
// Directed + randomized bench for palette_reader with a queue-based reference
// model and a behavioural palette RAM.
module tb_palette_reader;

  localparam int LINE = 256;

  logic        clock = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic        pix_ready;
  logic [4:0]  pix_index;
  logic        greyscale;
  logic        frame_start;
  logic [13:0] r_addr;
  logic [7:0]  r_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_color;
  logic        out_eol;

  palette_reader #(.PAL_BASE(14'h3F00), .LINE_PIXELS(LINE), .XW(9)) dut (
    .clock(clock), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_index(pix_index), .greyscale(greyscale), .frame_start(frame_start),
    .r_addr(r_addr), .r_data(r_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_color(out_color), .out_eol(out_eol)
  );

  always #5 clock = ~clock;

  logic [7:0] ram [32];
  assign r_data = ram[r_addr[4:0]];

  typedef struct packed { logic [5:0] color; logic eol; } exp_t;
  exp_t q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int line_cnt = 0;
  int n_out    = 0;
  int last_off = 0;
  logic       hold_pend = 1'b0;
  logic [5:0] hold_color;
  logic       hold_eol;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Colour index 0 of any palette shows the universal backdrop.
  function automatic int ref_offset(input logic [4:0] idx);
    int a = int'(idx);
    return (a % 4 == 0) ? 0 : a;
  endfunction

  function automatic logic [5:0] ref_color(input int off, input logic grey);
    int c = int'(ram[off]) % 64;
    if (grey) c = (c / 16) * 16;
    return 6'(c);
  endfunction

  // Called at edge+1 with inputs set; samples mid-cycle, advances one clock.
  task automatic tick(output logic ihs);
    logic ohs;
    exp_t e;
    int off;
    #3;
    ihs = pix_valid & pix_ready;
    ohs = out_valid & out_ready;
    check("r_addr", {2'b0, r_addr}, 16'h3F00 + 16'(last_off));
    if (hold_pend) begin
      check("hold_valid", {15'b0, out_valid}, 16'h1);
      check("hold_color", {10'b0, out_color}, {10'b0, hold_color});
      check("hold_eol", {15'b0, out_eol}, {15'b0, hold_eol});
    end
    hold_pend  = out_valid & ~out_ready;
    hold_color = out_color;
    hold_eol   = out_eol;
    if (ohs) begin
      if (q.size() == 0) check("spurious_out", {15'b0, out_valid}, 16'h0);
      else begin
        e = q.pop_front();
        check("out_color", {10'b0, out_color}, {10'b0, e.color});
        check("out_eol", {15'b0, out_eol}, {15'b0, e.eol});
        n_out++;
      end
    end
    if (ihs) begin
      off = ref_offset(pix_index);
      e.color = ref_color(off, greyscale);
      e.eol   = (line_cnt == LINE - 1);
      q.push_back(e);
      line_cnt = (line_cnt + 1) % LINE;
      last_off = off;
    end
    if (frame_start) line_cnt = 0;
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    logic ihs;
    int budget = 0;
    pix_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && budget < 20) begin
      tick(ihs);
      budget++;
    end
    check("drain_empty", 16'(q.size()), 16'h0);
  endtask

  task automatic run_stream(input int n);
    logic ihs;
    int sent = 0;
    int cycles = 0;
    while (sent < n || q.size() > 0) begin
      pix_valid = (sent < n) && ($urandom_range(3) != 0);
      pix_index = 5'($urandom);
      greyscale = 1'($urandom_range(3) == 0);
      out_ready = ($urandom_range(2) != 0);
      tick(ihs);
      if (ihs) sent++;
      cycles++;
      if (cycles > n * 10 + 50) begin
        check("stream_timeout", 16'(q.size()), 16'h0);
        break;
      end
    end
    pix_valid = 1'b0;
  endtask

  logic ihs;
  int   k;
  logic [4:0] offer [4];
  int   out_base;

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 8'($urandom);
    ram[5] = 8'h2A;
    ram[0] = 8'h0F;
    reset = 1'b1; pix_valid = 1'b0; pix_index = '0; greyscale = 1'b0;
    frame_start = 1'b0; out_ready = 1'b0;
    @(posedge clock); #1;
    check("rst_out_valid", {15'b0, out_valid}, 16'h0);
    check("rst_r_addr", {2'b0, r_addr}, 16'h3F00);
    reset = 1'b0;

    // 1: reset while a pixel sits in Out and another in S1
    pix_valid = 1'b1; pix_index = 5'h05; out_ready = 1'b0;
    tick(ihs);
    pix_index = 5'h07;
    tick(ihs);
    pix_valid = 1'b0;
    tick(ihs);
    check("pre_rst_valid", {15'b0, out_valid}, 16'h1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_valid", {15'b0, out_valid}, 16'h0);
    check("rst_mid_color", {10'b0, out_color}, 16'h0);
    check("rst_mid_eol", {15'b0, out_eol}, 16'h0);
    check("rst_mid_r_addr", {2'b0, r_addr}, 16'h3F00);
    q.delete(); last_off = 0; line_cnt = 0; hold_pend = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    tick(ihs);
    tick(ihs);
    check("post_rst_idle", {15'b0, out_valid}, 16'h0);

    // 2: latency, r_addr at N+1 and colour at N+2
    pix_valid = 1'b1; pix_index = 5'h05; greyscale = 1'b0; out_ready = 1'b1;
    tick(ihs);
    pix_valid = 1'b0;
    check("lat_r_addr", {2'b0, r_addr}, 16'h3F05);
    check("lat_n1_valid", {15'b0, out_valid}, 16'h0);
    tick(ihs);
    check("lat_n2_valid", {15'b0, out_valid}, 16'h1);
    check("lat_n2_color", {10'b0, out_color}, 16'h002A);
    tick(ihs);

    // 3: backdrop and mirroring addresses
    pix_valid = 1'b1; pix_index = 5'h10;
    tick(ihs);
    check("map_10", {2'b0, r_addr}, 16'h3F00);
    pix_index = 5'h13;
    tick(ihs);
    check("map_13", {2'b0, r_addr}, 16'h3F13);
    check("map_10_color", {10'b0, out_color}, 16'h000F);
    pix_index = 5'h04;
    tick(ihs);
    check("map_04", {2'b0, r_addr}, 16'h3F00);
    drain();

    // 4: greyscale on and off for the same entry
    pix_valid = 1'b1; pix_index = 5'h05; greyscale = 1'b1;
    tick(ihs);
    greyscale = 1'b0;
    tick(ihs);
    pix_valid = 1'b0;
    check("grey_on", {10'b0, out_color}, 16'h0020);
    tick(ihs);
    check("grey_off", {10'b0, out_color}, 16'h002A);
    drain();

    // 5: five stalled cycles with four pixels offered
    offer[0] = 5'h01; offer[1] = 5'h06; offer[2] = 5'h0B; offer[3] = 5'h1E;
    k = 0; out_base = n_out; out_ready = 1'b0; greyscale = 1'b0;
    for (int c = 0; c < 5; c++) begin
      pix_valid = (k < 4);
      pix_index = offer[k % 4];
      tick(ihs);
      if (ihs) k++;
    end
    check("stall_accepted", 16'(k), 16'd2);
    out_ready = 1'b1;
    for (int c = 0; c < 10 && k < 4; c++) begin
      pix_valid = 1'b1;
      pix_index = offer[k];
      tick(ihs);
      if (ihs) k++;
    end
    drain();
    check("stall_delivered", 16'(n_out - out_base), 16'd4);

    // 6: line framing under random backpressure, then a mid-line restart
    frame_start = 1'b1;
    tick(ihs);
    frame_start = 1'b0;
    out_base = n_out;
    run_stream(LINE);
    check("line1_count", 16'(n_out - out_base), 16'(LINE));
    run_stream(100);
    drain();
    frame_start = 1'b1;
    tick(ihs);
    frame_start = 1'b0;
    out_base = n_out;
    run_stream(LINE);
    check("line2_count", 16'(n_out - out_base), 16'(LINE));
    check("final_queue", 16'(q.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
